// File: rtl/cdp1802_dma_out_responder_if.sv
// Memory-bus and video-side signals of the CDP1802 DMA-out responder.
// master = responder, slave = memory plus video block.
interface cdp1802_dma_out_responder_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready;
    logic [7:0]        mem_data;
    logic              dma_out_n;
    logic [7:0]        data_out;
    logic              mem_ack;

    modport master (
        output mem_addr,
        output mem_rd,
        output data_out,
        output mem_ack,
        input  mem_ready,
        input  mem_data,
        input  dma_out_n
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  data_out,
        input  mem_ack,
        output mem_ready,
        output mem_data,
        output dma_out_n
    );
endinterface

// File: rtl/cdp1802_dma_out_responder.sv
// CDP1802 DMA-out responder: steals S2 cycles to feed the Pixie from R0.
// One byte per machine cycle while the request is held, R0 post-increments.
module cdp1802_dma_out_responder #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] R0_RESET = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              cpu_boundary,
    input  logic              r0_load,
    input  logic [ADDR_W-1:0] r0_value,
    output logic [ADDR_W-1:0] r0,
    output logic              cpu_hold,
    output logic [1:0]        SC,
    output logic              timeout_err,
    cdp1802_dma_out_responder_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] r0_nxt;
    logic              hold_nxt;
    logic [1:0]        sc_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              rd_q, rd_nxt;
    logic [7:0]        data_q, data_nxt;
    logic              ack_q, ack_nxt;
    logic              terr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            r0          <= R0_RESET;
            cpu_hold    <= 1'b0;
            SC          <= 2'b00;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            data_q      <= 8'h00;
            ack_q       <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            r0          <= r0_nxt;
            cpu_hold    <= hold_nxt;
            SC          <= sc_nxt;
            addr_q      <= addr_nxt;
            rd_q        <= rd_nxt;
            data_q      <= data_nxt;
            ack_q       <= ack_nxt;
            timeout_err <= terr_nxt;
            cnt         <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = cpu_hold;
        sc_nxt    = SC;
        addr_nxt  = addr_q;
        rd_nxt    = rd_q;
        data_nxt  = data_q;
        ack_nxt   = 1'b0;
        terr_nxt  = timeout_err;
        cnt_nxt   = cnt;
        inc       = 1'b0;
        unique case (state)
            IDLE: begin
                if (clk_enable && cpu_boundary && !bus.dma_out_n) begin
                    hold_nxt  = 1'b1;
                    sc_nxt    = 2'b10;
                    addr_nxt  = r0;
                    rd_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // a late mem_ready on the last counted clock still wins
                if (bus.mem_ready) begin
                    data_nxt  = bus.mem_data;
                    ack_nxt   = 1'b1;
                    rd_nxt    = 1'b0;
                    inc       = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    data_nxt  = 8'h00;
                    ack_nxt   = 1'b1;
                    rd_nxt    = 1'b0;
                    inc       = 1'b1;
                    terr_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                if (clk_enable) begin
                    if (!bus.dma_out_n) begin
                        addr_nxt  = r0;
                        rd_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = FETCH;
                    end else begin
                        sc_nxt    = 2'b00;
                        hold_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        r0_nxt = r0_load ? r0_value : (inc ? r0 + 1'b1 : r0);
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_rd   = rd_q;
    assign bus.data_out = data_q;
    assign bus.mem_ack  = ack_q;
endmodule

// File: tb/tb_cdp1802_dma_out_responder.sv
// Bench for the DMA-out responder: directed stimulus, queued expectations,
// and a monitor that checks every mem_ack against the queue.
module tb_cdp1802_dma_out_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        cpu_boundary;
    logic        r0_load;
    logic [15:0] r0_value;
    logic [15:0] r0;
    logic        cpu_hold;
    logic [1:0]  SC;
    logic        timeout_err;

    cdp1802_dma_out_responder_if #(.ADDR_W(16)) bus ();

    cdp1802_dma_out_responder #(
        .ADDR_W(16),
        .R0_RESET(16'h0000),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_enable(clk_enable),
        .cpu_boundary(cpu_boundary),
        .r0_load(r0_load),
        .r0_value(r0_value),
        .r0(r0),
        .cpu_hold(cpu_hold),
        .SC(SC),
        .timeout_err(timeout_err),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] r0;
        logic        terr;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   ack_count = 0;
    int   exp_acks = 0;
    int   mem_delay = 1;
    int   wait_cnt = 0;
    int   rd_clks = 0;
    int   hold_drops = 0;
    bit   hold_watch = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // memory: mem_ready after mem_delay clocks of mem_rd (0 = never)
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_rd === 1'b1) begin
                wait_cnt++;
                rd_clks++;
                if (mem_delay != 0 && wait_cnt == mem_delay) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_data  = bus.mem_addr[7:0] ^ 8'hA5;
                end else begin
                    bus.mem_ready = 1'b0;
                end
            end else begin
                wait_cnt      = 0;
                bus.mem_ready = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (hold_watch && (cpu_hold !== 1'b1 || SC !== 2'b10))
                hold_drops++;
            if (bus.mem_ack === 1'b1) begin
                ack_count++;
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_ack: got data %h expected none",
                             bus.data_out);
                end else begin
                    e = sb.pop_front();
                    chk("ack_addr", {16'h0, bus.mem_addr}, {16'h0, e.addr});
                    chk("ack_data", {24'h0, bus.data_out}, {24'h0, e.data});
                    chk("ack_r0", {16'h0, r0}, {16'h0, e.r0});
                    chk("ack_terr", {31'h0, timeout_err}, {31'h0, e.terr});
                    chk("ack_sc_hold", {29'h0, SC, cpu_hold}, 32'h5);
                end
            end
        end
    end

    task automatic expect_byte(input logic [15:0] a, input logic [7:0] d,
                               input logic [15:0] r, input logic t);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.r0   = r;
        e.terr = t;
        sb.push_back(e);
        exp_acks++;
    endtask

    task automatic strobe(input logic req, input logic bnd,
                          input logic coll, input logic [15:0] cval);
        @(negedge clk);
        bus.dma_out_n = ~req;
        cpu_boundary  = bnd;
        clk_enable    = 1'b1;
        rd_clks       = 0;
        @(negedge clk);
        clk_enable = 1'b0;
        if (coll) begin
            r0_load  = 1'b1;
            r0_value = cval;
        end
        @(negedge clk);
        r0_load = 1'b0;
    endtask

    task automatic load_r0(input logic [15:0] v);
        @(negedge clk);
        r0_load  = 1'b1;
        r0_value = v;
        @(negedge clk);
        r0_load = 1'b0;
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 40 && ack_count < exp_acks; i++) @(negedge clk);
        chk("ack_arrived", ack_count, exp_acks);
    endtask

    task automatic release_req(input string name);
        strobe(1'b0, 1'b1, 1'b0, 16'h0);
        chk(name, {30'h0, SC}, 32'h0);
        chk({name, "_hold"}, {31'h0, cpu_hold}, 32'h0);
    endtask

    logic [7:0] burst_d [8];

    initial begin
        burst_d = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2};
        reset         = 1'b1;
        clk_enable    = 1'b0;
        cpu_boundary  = 1'b0;
        r0_load       = 1'b0;
        r0_value      = 16'h0;
        bus.dma_out_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_r0", {16'h0, r0}, 32'h0);
        chk("rst_hold_sc", {29'h0, SC, cpu_hold}, 32'h0);
        chk("rst_mem", {14'h0, bus.mem_addr, bus.mem_rd, bus.mem_ack}, 32'h0);
        chk("rst_data", {23'h0, bus.data_out, timeout_err}, 32'h0);
        reset = 1'b0;

        // single byte
        load_r0(16'h0900);
        chk("load_r0", {16'h0, r0}, 32'h0900);
        expect_byte(16'h0900, 8'hA5, 16'h0901, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 16'h0);
        wait_ack();
        chk("single_rd_clks", rd_clks, 1);
        release_req("single_release");

        // 8-byte burst
        load_r0(16'h0900);
        for (int i = 0; i < 8; i++) begin
            expect_byte(16'h0900 + 16'(i), burst_d[i], 16'h0901 + 16'(i), 1'b0);
            strobe(1'b1, 1'b1, 1'b0, 16'h0);
            hold_watch = 1'b1;
            wait_ack();
        end
        hold_watch = 1'b0;
        chk("burst_hold_drops", hold_drops, 0);
        chk("burst_r0", {16'h0, r0}, 32'h0908);
        release_req("burst_release");

        // wrap
        load_r0(16'hFFFF);
        expect_byte(16'hFFFF, 8'h5A, 16'h0000, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 16'h0);
        wait_ack();
        expect_byte(16'h0000, 8'hA5, 16'h0001, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 16'h0);
        wait_ack();
        release_req("wrap_release");

        // slow memory
        mem_delay = 5;
        load_r0(16'h1234);
        expect_byte(16'h1234, 8'h91, 16'h1235, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 16'h0);
        wait_ack();
        chk("slow_rd_clks", rd_clks, 5);
        release_req("slow_release");

        // r0_load collides with mem_ready
        mem_delay = 1;
        load_r0(16'h0B10);
        expect_byte(16'h0B10, 8'hB5, 16'h0A00, 1'b0);
        strobe(1'b1, 1'b1, 1'b1, 16'h0A00);
        wait_ack();
        expect_byte(16'h0A00, 8'hA5, 16'h0A01, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 16'h0);
        wait_ack();
        release_req("coll_release");

        // request without cpu_boundary is ignored
        load_r0(16'h0C03);
        strobe(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (4) @(negedge clk);
        chk("gate_no_rd", rd_clks, 0);
        chk("gate_no_hold", {31'h0, cpu_hold}, 32'h0);
        expect_byte(16'h0C03, 8'hA6, 16'h0C04, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 16'h0);
        wait_ack();
        release_req("gate_release");

        // timeout
        mem_delay = 0;
        load_r0(16'h2000);
        expect_byte(16'h2000, 8'h00, 16'h2001, 1'b1);
        strobe(1'b1, 1'b1, 1'b0, 16'h0);
        wait_ack();
        chk("tmo_rd_clks", rd_clks, 15);
        release_req("tmo_release");
        repeat (5) @(negedge clk);
        chk("tmo_sticky", {31'h0, timeout_err}, 32'h1);

        // reset mid-fetch
        load_r0(16'h3000);
        strobe(1'b1, 1'b1, 1'b0, 16'h0);
        chk("mid_rd_before", {31'h0, bus.mem_rd}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rd", {31'h0, bus.mem_rd}, 32'h0);
        chk("mid_hold_sc", {29'h0, SC, cpu_hold}, 32'h0);
        chk("mid_r0", {16'h0, r0}, 32'h0);
        chk("mid_terr", {31'h0, timeout_err}, 32'h0);
        chk("mid_ack", {31'h0, bus.mem_ack}, 32'h0);
        reset = 1'b0;
        bus.dma_out_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("end_acks", ack_count, exp_acks);
        chk("end_queue", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
